ysyx_22050019_axi_rd_arbiter: RTL and testbench
===============================================

Name:
ysyx_22050019_axi_rd_arbiter

Overview:
- Two-master AXI read-channel arbiter between the IFU (m0) and LSU/cache (m1) and the single shared AXI memory slave.
- Grants one master at a time and forwards its AR request.
- Routes every R beat back to the granted master only, and holds the grant until the burst's last beat handshakes.
- Write channels bypass this block.

Parameters:
AXI_DATA_WIDTH, 64, data bus width of all R channels
AXI_ADDR_WIDTH, 32, address width of all AR channels

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m0_ar_valid  in  1  IFU read request
m0_ar_ready  out  1  IFU address accepted
m0_ar_addr  in  AXI_ADDR_WIDTH  IFU read address
m0_ar_len  in  8  IFU burst length minus 1
m0_r_valid  out  1  IFU read data valid
m0_r_ready  in  1  IFU read data ready
m0_r_data  out  AXI_DATA_WIDTH  IFU read data
m0_r_last  out  1  IFU last beat
m1_ar_valid  in  1  LSU read request
m1_ar_ready  out  1  LSU address accepted
m1_ar_addr  in  AXI_ADDR_WIDTH  LSU read address
m1_ar_len  in  8  LSU burst length minus 1
m1_r_valid  out  1  LSU read data valid
m1_r_ready  in  1  LSU read data ready
m1_r_data  out  AXI_DATA_WIDTH  LSU read data
m1_r_last  out  1  LSU last beat
s_ar_valid  out  1  slave read request (registered)
s_ar_ready  in  1  slave address accepted
s_ar_addr  out  AXI_ADDR_WIDTH  slave read address (registered)
s_ar_len  out  8  slave burst length (registered)
s_r_valid  in  1  slave read data valid
s_r_ready  out  1  slave read data ready
s_r_data  in  AXI_DATA_WIDTH  slave read data
s_r_last  in  1  slave last beat

Behaviour:
- **Reset.** Clock is `clk`; reset `rst` is synchronous and active-high. On reset: state=IDLE, grant=0, last_grant=0, s_ar_valid=0, s_ar_addr=0, s_ar_len=0. All combinational outputs are 0 while in IDLE.
- **IDLE.**
  - If any mX_ar_valid is high, pick a winner. Fixed priority: m1 beats m0.
  - Latch the winner's addr/len into s_ar_addr/s_ar_len, set grant, set s_ar_valid=1 at the next edge, and go to AR.
  - AR-side latency from request to slave request is one cycle.
- **AR.**
  - s_ar_valid is held at 1 until s_ar_ready.
  - On s_ar_valid&s_ar_ready: clear s_ar_valid and go to R.
  - m{grant}_ar_ready = (state==AR) & s_ar_ready, combinational, so the master handshake coincides with the slave handshake. Masters hold ar_valid/addr stable until ready.
- **R.**
  - m{grant}_r_valid = s_r_valid and s_r_ready = m{grant}_r_ready.
  - mX_r_data = s_r_data and mX_r_last = s_r_last are broadcast to both masters; the non-granted master sees r_valid=0.
  - On s_r_valid&s_r_ready&s_r_last: go to IDLE and set last_grant=grant.
- **Non-granted master.** ar_ready=0 and r_valid=0 at all times.
- **Stray slave data.** s_r_ready=0 outside R; s_r_valid outside R is ignored.
- **Back-to-back requests.** A new grant is decided no earlier than the cycle after the last beat, so there is at least one IDLE cycle between bursts.
- **Requests during a burst.** A request arriving mid-burst waits; it is not dropped.
- **Reset mid-operation.** Reset asserted in AR or R returns to IDLE at that edge; the in-flight transaction is abandoned and outputs return to reset values.
- **Illegal state.** An illegal state encoding goes to IDLE.

Optional Feature:
- Macro: YSYX_22050019_ARB_RR_EN.
- Defined: round-robin arbitration. When both masters request in IDLE, the grant goes to the master != last_grant; a single requester always wins.
- Undefined: fixed priority, m1 over m0, and last_grant is unused.

Test Plan:
1. m0 reads 0x80000000, len 0 -> s_ar_valid=1 with s_ar_addr=0x80000000 one cycle later; m0_ar_ready pulses with s_ar_ready; slave data 0x1122334455667788 appears on m0_r_data with m0_r_valid=1, m0_r_last=1; m1_r_valid=0; back to IDLE.
2. m0 and m1 request in the same cycle (0x80000000 / 0x80001000) -> m1 served first, m0 served after m1's last beat. With RR_EN, a second simultaneous pair is served m0 first.
3. m1 bursts len 3 from 0x80002000; m0 requests during beat 2 -> 4 beats go to m1 only; m0_ar_ready stays 0 until ≥1 cycle after m1_r_last.
4. m0_r_ready held low 3 cycles mid-burst -> s_r_ready low for the same 3 cycles; no beat lost or duplicated; the beat count still equals len+1.
5. rst asserted while in R with 2 beats outstanding -> next cycle s_ar_valid=0, s_r_ready=0, all m_*_valid/ready=0; a new m0 request afterwards is served normally.

Source files
------------

// File: rtl/ysyx_22050019_axi_rd_arbiter.sv
// Two-master AXI read-channel arbiter (m0 = IFU, m1 = LSU/cache) in front of one shared slave.
// Optional macro YSYX_22050019_ARB_RR_EN selects round-robin instead of fixed m1-over-m0 priority.
module ysyx_22050019_axi_rd_arbiter #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m0_ar_valid,
    output logic                      m0_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] m0_ar_addr,
    input  logic [7:0]                m0_ar_len,
    output logic                      m0_r_valid,
    input  logic                      m0_r_ready,
    output logic [AXI_DATA_WIDTH-1:0] m0_r_data,
    output logic                      m0_r_last,
    input  logic                      m1_ar_valid,
    output logic                      m1_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] m1_ar_addr,
    input  logic [7:0]                m1_ar_len,
    output logic                      m1_r_valid,
    input  logic                      m1_r_ready,
    output logic [AXI_DATA_WIDTH-1:0] m1_r_data,
    output logic                      m1_r_last,
    output logic                      s_ar_valid,
    input  logic                      s_ar_ready,
    output logic [AXI_ADDR_WIDTH-1:0] s_ar_addr,
    output logic [7:0]                s_ar_len,
    input  logic                      s_r_valid,
    output logic                      s_r_ready,
    input  logic [AXI_DATA_WIDTH-1:0] s_r_data,
    input  logic                      s_r_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      grant_q, grant_d;
    logic                      s_ar_valid_q, s_ar_valid_d;
    logic [AXI_ADDR_WIDTH-1:0] s_ar_addr_q, s_ar_addr_d;
    logic [7:0]                s_ar_len_q, s_ar_len_d;
    logic                      winner;
    logic                      in_ar, in_r;

`ifdef YSYX_22050019_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // On a tie the master served last yields; a lone requester always wins.
    always_comb begin
        winner = m1_ar_valid;
        if (m0_ar_valid && m1_ar_valid) winner = ~last_grant_q;
    end
`else
    always_comb winner = m1_ar_valid;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        s_ar_valid_d = s_ar_valid_q;
        s_ar_addr_d  = s_ar_addr_q;
        s_ar_len_d   = s_ar_len_q;
`ifdef YSYX_22050019_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_ar_valid || m1_ar_valid) begin
                    grant_d      = winner;
                    s_ar_addr_d  = winner ? m1_ar_addr : m0_ar_addr;
                    s_ar_len_d   = winner ? m1_ar_len  : m0_ar_len;
                    s_ar_valid_d = 1'b1;
                    state_d      = AR;
                end
            end
            AR: begin
                if (s_ar_ready) begin
                    s_ar_valid_d = 1'b0;
                    state_d      = R;
                end
            end
            R: begin
                if (s_r_valid && s_r_ready && s_r_last) begin
                    state_d = IDLE;
`ifdef YSYX_22050019_ARB_RR_EN
                    last_grant_d = grant_q;
`endif
                end
            end
            default: begin
                state_d      = IDLE;
                s_ar_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            s_ar_valid_q <= 1'b0;
            s_ar_addr_q  <= '0;
            s_ar_len_q   <= '0;
`ifdef YSYX_22050019_ARB_RR_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            s_ar_valid_q <= s_ar_valid_d;
            s_ar_addr_q  <= s_ar_addr_d;
            s_ar_len_q   <= s_ar_len_d;
`ifdef YSYX_22050019_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign in_ar = (state_q == AR);
    assign in_r  = (state_q == R);

    assign s_ar_valid = s_ar_valid_q;
    assign s_ar_addr  = s_ar_addr_q;
    assign s_ar_len   = s_ar_len_q;

    // AR ready passes straight through so master and slave handshake on the same edge.
    assign m0_ar_ready = in_ar & s_ar_ready & ~grant_q;
    assign m1_ar_ready = in_ar & s_ar_ready &  grant_q;

    assign m0_r_valid = in_r & s_r_valid & ~grant_q;
    assign m1_r_valid = in_r & s_r_valid &  grant_q;
    assign s_r_ready  = in_r & (grant_q ? m1_r_ready : m0_r_ready);

    assign m0_r_data = in_r ? s_r_data : '0;
    assign m1_r_data = in_r ? s_r_data : '0;
    assign m0_r_last = in_r & s_r_last;
    assign m1_r_last = in_r & s_r_last;

endmodule

// File: tb/tb_ysyx_22050019_axi_rd_arbiter.sv
// Randomized bench for the AXI read arbiter: master/slave models plus a burst-level scoreboard.
`timescale 1ns/1ps
module tb_ysyx_22050019_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  m_req = '0;
    logic [1:0]  m_rr = '0;
    logic [31:0] m_addr [2];
    logic [7:0]  m_len  [2];
    logic        s_ar_ready = 1'b0;
    logic        s_r_valid = 1'b0;
    logic        s_r_last = 1'b0;
    logic [63:0] s_r_data = '0;

    logic        m0_ar_ready, m1_ar_ready, m0_r_valid, m1_r_valid, m0_r_last, m1_r_last;
    logic [63:0] m0_r_data, m1_r_data;
    logic        s_ar_valid, s_r_ready;
    logic [31:0] s_ar_addr;
    logic [7:0]  s_ar_len;

    logic [1:0]  o_arready, o_rvalid, o_rlast;
    logic [63:0] o_rdata [2];
    assign o_arready = {m1_ar_ready, m0_ar_ready};
    assign o_rvalid  = {m1_r_valid, m0_r_valid};
    assign o_rlast   = {m1_r_last, m0_r_last};
    assign o_rdata[0] = m0_r_data;
    assign o_rdata[1] = m1_r_data;

    ysyx_22050019_axi_rd_arbiter #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_ar_valid(m_req[0]), .m0_ar_ready(m0_ar_ready), .m0_ar_addr(m_addr[0]), .m0_ar_len(m_len[0]),
        .m0_r_valid(m0_r_valid), .m0_r_ready(m_rr[0]), .m0_r_data(m0_r_data), .m0_r_last(m0_r_last),
        .m1_ar_valid(m_req[1]), .m1_ar_ready(m1_ar_ready), .m1_ar_addr(m_addr[1]), .m1_ar_len(m_len[1]),
        .m1_r_valid(m1_r_valid), .m1_r_ready(m_rr[1]), .m1_r_data(m1_r_data), .m1_r_last(m1_r_last),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_last(s_r_last)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] a;
        logic [7:0]  l;
    } burst_t;

    int checks = 0, errors = 0;
    // scoreboard state
    logic [1:0]  out_active = '0;
    logic [31:0] out_addr [2];
    int          out_len [2], out_beat [2];
    int          beats [2] = '{0, 0};
    int          done [2] = '{0, 0};
    logic [63:0] last_data [2];
    logic        last_last [2];
    int          order [$];
    int          last_done = 0;
    bit          have_last = 0;
    int          last_cyc = 0, cyc = 0;
    int          data_err = 0, last_err = 0, route_err = 0, stray_err = 0;
    int          ar_err = 0, overlap_err = 0, gap_err = 0;
    logic [1:0]  clr_req = '0;
    // slave model
    burst_t      s_q [$];
    int          s_beat = 0;
    bit          s_rhs_flag = 0;
    int          m_rmode [2] = '{1, 1};   // 0 random, 1 high, 2 low
    int          s_ar_mode = 1;           // 0 low, 1 high, 2 random
    int          s_r_mode = 1;            // 0 random, 1 always when data pending

    function automatic logic [63:0] fn(input logic [31:0] a, input int b);
        return ({a, 32'h0} ^ 64'h9122_3344_5566_7788) + 64'(b);
    endfunction

    function automatic int errs();
        return data_err + last_err + route_err + stray_err + ar_err + overlap_err + gap_err;
    endfunction

    task automatic observe();
        logic [1:0] hs;
        logic       any_m_rhs, s_rhs;
        cyc++;
        hs = m_req & o_arready;
        if (o_arready == 2'b11) overlap_err++;
        for (int m = 0; m < 2; m++) begin
            if (o_arready[m] === 1'b1 && out_active != 0) overlap_err++;
            if (hs[m] === 1'b1) begin
                if (!(s_ar_valid === 1'b1 && s_ar_ready && s_ar_addr === m_addr[m] && s_ar_len === m_len[m])) ar_err++;
                if (have_last && cyc < last_cyc + 2) gap_err++;
                order.push_back(m);
                out_active[m] = 1'b1;
                out_addr[m] = m_addr[m];
                out_len[m] = int'(m_len[m]);
                out_beat[m] = 0;
                clr_req[m] = 1'b1;
            end
        end
        if (s_ar_valid === 1'b1 && s_ar_ready) begin
            if (hs == 2'b00) ar_err++;
            s_q.push_back('{a: s_ar_addr, l: s_ar_len});
        end
        if (o_rvalid === 2'b11) stray_err++;
        any_m_rhs = 1'b0;
        for (int m = 0; m < 2; m++) begin
            if (o_rvalid[m] === 1'b1 && !out_active[m]) stray_err++;
            if (o_rvalid[m] === 1'b1 && m_rr[m] && out_active[m]) begin
                any_m_rhs = 1'b1;
                if (o_rdata[m] !== fn(out_addr[m], out_beat[m])) data_err++;
                if (o_rlast[m] !== (out_beat[m] == out_len[m])) last_err++;
                last_data[m] = o_rdata[m];
                last_last[m] = o_rlast[m];
                beats[m]++;
                out_beat[m]++;
                if (out_beat[m] > out_len[m]) begin
                    out_active[m] = 1'b0;
                    done[m]++;
                    last_done = m;
                    have_last = 1;
                    last_cyc = cyc;
                end
            end
        end
        s_rhs = (s_r_valid && s_r_ready === 1'b1);
        if (s_rhs != any_m_rhs) route_err++;
        if (s_rhs && s_q.size() > 0) begin
            s_beat++;
            if (s_beat > int'(s_q[0].l)) begin
                void'(s_q.pop_front());
                s_beat = 0;
            end
        end
        s_rhs_flag = s_rhs;
    endtask

    task automatic apply();
        for (int m = 0; m < 2; m++) begin
            if (clr_req[m]) begin
                m_req[m] = 1'b0;
                clr_req[m] = 1'b0;
            end
            case (m_rmode[m])
                0: m_rr[m] = 1'($urandom_range(0, 1));
                1: m_rr[m] = 1'b1;
                default: m_rr[m] = 1'b0;
            endcase
        end
        case (s_ar_mode)
            0: s_ar_ready = 1'b0;
            1: s_ar_ready = 1'b1;
            default: s_ar_ready = 1'($urandom_range(0, 1));
        endcase
        if (!(s_r_valid && !s_rhs_flag)) begin
            if (s_q.size() > 0 && (s_r_mode == 1 || $urandom_range(0, 1) == 1)) begin
                s_r_valid = 1'b1;
                s_r_data = fn(s_q[0].a, s_beat);
                s_r_last = (s_beat == int'(s_q[0].l));
            end else begin
                s_r_valid = 1'b0;
                s_r_data = {$urandom, $urandom};
                s_r_last = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic issue(input int m, input logic [31:0] a, input logic [7:0] l);
        m_req[m] = 1'b1;
        m_addr[m] = a;
        m_len[m] = l;
    endtask

    task automatic run_idle(input int budget, output bit to);
        int n;
        n = 0;
        to = 0;
        while ((m_req != 0 || out_active != 0 || s_q.size() != 0) && !to) begin
            tick();
            n++;
            if (n >= budget) to = 1;
        end
    endtask

    task automatic test_reset();
        m_addr[0] = 32'h1234_5678; m_addr[1] = 32'h9abc_def0;
        m_len[0] = 8'h5; m_len[1] = 8'h7;
        m_rr = 2'b11;
        s_r_valid = 1'b1; s_r_last = 1'b1; s_r_data = 64'hdead_beef_cafe_f00d;
        s_ar_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_ar_valid, s_r_ready, o_arready, o_rvalid, o_rlast} !== 8'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000000", {s_ar_valid, s_r_ready, o_arready, o_rvalid, o_rlast});
        end
        checks++;
        if (s_ar_addr !== 32'h0 || s_ar_len !== 8'h0) begin
            errors++;
            $display("FAIL reset_ar: addr %h len %h want 0/0", s_ar_addr, s_ar_len);
        end
        checks++;
        if (m0_r_data !== 64'h0 || m1_r_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: m0 %h m1 %h want 0", m0_r_data, m1_r_data);
        end
        rst = 1'b0;
        s_r_valid = 1'b0;
        tick();
        checks++;
        if (s_ar_valid !== 1'b0 || s_r_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: s_ar_valid %b s_r_ready %b want 0 0", s_ar_valid, s_r_ready);
        end
    endtask

    task automatic test_stray();
        s_r_valid = 1'b1; s_r_last = 1'b1; s_r_data = 64'h0bad_0bad_0bad_0bad;
        m_rr = 2'b11;
        #2;
        checks++;
        if (s_r_ready !== 1'b0 || o_rvalid !== 2'b00) begin
            errors++;
            $display("FAIL stray_r: s_r_ready %b r_valid %b want 0 00", s_r_ready, o_rvalid);
        end
        s_r_valid = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit to;
        s_ar_mode = 0; s_ar_ready = 1'b0; s_r_mode = 1;
        m_rmode = '{1, 1};
        issue(0, 32'h8000_0000, 8'd0);
        #2;
        checks++;
        if (s_ar_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_latency_pre: s_ar_valid %b want 0", s_ar_valid);
        end
        tick();
        #2;
        checks++;
        if (s_ar_valid !== 1'b1 || s_ar_addr !== 32'h8000_0000 || s_ar_len !== 8'd0 || m0_ar_ready !== 1'b0) begin
            errors++;
            $display("FAIL ar_latency: valid %b addr %h len %h m0_ar_ready %b want 1 80000000 00 0",
                     s_ar_valid, s_ar_addr, s_ar_len, m0_ar_ready);
        end
        s_ar_mode = 1; s_ar_ready = 1'b1;
        #1;
        checks++;
        if (o_arready !== 2'b01) begin
            errors++;
            $display("FAIL ar_ready_pass: got %b want 01", o_arready);
        end
        run_idle(50, to);
        checks++;
        if (to || beats[0] != 1 || beats[1] != 0) begin
            errors++;
            $display("FAIL single_beats: timeout %0d m0 %0d m1 %0d want 0 1 0", to, beats[0], beats[1]);
        end
        checks++;
        if (last_data[0] !== 64'h1122_3344_5566_7788 || last_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_data: data %h last %b want 1122334455667788 1", last_data[0], last_last[0]);
        end
        checks++;
        if (errs() != 0 || s_ar_valid !== 1'b0 || s_r_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_clean: errs %0d s_ar_valid %b s_r_ready %b want 0 0 0", errs(), s_ar_valid, s_r_ready);
        end
    endtask

    task automatic test_priority();
        bit to;
        int exp_first;
        s_ar_mode = 2; s_r_mode = 0; m_rmode = '{0, 0};
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                issue(1, 32'h8000_1800, 8'd1);
                run_idle(200, to);
            end
`ifdef YSYX_22050019_ARB_RR_EN
            exp_first = 1 - last_done;
`else
            exp_first = 1;
`endif
            order.delete();
            issue(0, 32'h8000_0000, 8'($urandom_range(0, 3)));
            issue(1, 32'h8000_1000, 8'($urandom_range(0, 3)));
            run_idle(400, to);
            checks++;
            if (to || order.size() != 2 || order[0] != exp_first || order[1] != 1 - exp_first) begin
                errors++;
                $display("FAIL priority_order%0d: timeout %0d n %0d first %0d want first %0d",
                         pass, to, order.size(), (order.size() > 0) ? order[0] : -1, exp_first);
            end
        end
        checks++;
        if (errs() != 0) begin
            errors++;
            $display("FAIL priority_clean: errs %0d want 0", errs());
        end
    endtask

    task automatic test_mid_burst();
        bit to;
        int b0, b1, n;
        s_ar_mode = 1; s_r_mode = 1; m_rmode = '{1, 1};
        b0 = beats[0]; b1 = beats[1];
        order.delete();
        issue(1, 32'h8000_2000, 8'd3);
        n = 0;
        while (beats[1] - b1 < 2 && n < 50) begin
            tick();
            n++;
        end
        issue(0, 32'h8000_3000, 8'd0);
        run_idle(200, to);
        checks++;
        if (to || beats[1] - b1 != 4 || beats[0] - b0 != 1) begin
            errors++;
            $display("FAIL mid_burst_beats: timeout %0d m1 %0d m0 %0d want 0 4 1", to, beats[1] - b1, beats[0] - b0);
        end
        checks++;
        if (order.size() != 2 || order[0] != 1 || overlap_err != 0 || gap_err != 0) begin
            errors++;
            $display("FAIL mid_burst_wait: n %0d first %0d overlap %0d gap %0d want 2 1 0 0",
                     order.size(), (order.size() > 0) ? order[0] : -1, overlap_err, gap_err);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int b0, n, held;
        s_ar_mode = 1; s_r_mode = 1; m_rmode = '{1, 1};
        b0 = beats[0];
        issue(0, 32'h8000_4000, 8'd7);
        n = 0;
        while (beats[0] - b0 < 3 && n < 50) begin
            tick();
            n++;
        end
        held = beats[0];
        m_rmode[0] = 2; m_rr[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (s_r_ready !== 1'b0 || m0_r_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_cycle%0d: s_r_ready %b m0_r_valid %b want 0 1", i, s_r_ready, m0_r_valid);
            end
            tick();
        end
        m_rmode[0] = 1; m_rr[0] = 1'b1;
        run_idle(200, to);
        checks++;
        if (to || beats[0] - b0 != 8 || held - b0 < 3) begin
            errors++;
            $display("FAIL stall_beats: timeout %0d beats %0d want 0 8", to, beats[0] - b0);
        end
        checks++;
        if (errs() != 0) begin
            errors++;
            $display("FAIL stall_clean: errs %0d want 0", errs());
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int b0, n;
        s_ar_mode = 1; s_r_mode = 1; m_rmode = '{1, 1};
        b0 = beats[0];
        issue(0, 32'h8000_5000, 8'd3);
        n = 0;
        while (beats[0] - b0 < 2 && n < 50) begin
            tick();
            n++;
        end
        rst = 1'b1;
        m_req = '0; clr_req = '0; out_active = '0;
        s_q.delete(); s_beat = 0; s_r_valid = 1'b0; s_rhs_flag = 0;
        tick();
        #2;
        checks++;
        if ({s_ar_valid, s_r_ready, o_arready, o_rvalid} !== 6'h0 || s_ar_addr !== 32'h0 || s_ar_len !== 8'h0) begin
            errors++;
            $display("FAIL reset_mid: ctrl %b addr %h len %h want 000000 0 0",
                     {s_ar_valid, s_r_ready, o_arready, o_rvalid}, s_ar_addr, s_ar_len);
        end
        rst = 1'b0;
        b0 = beats[0];
        issue(0, 32'h8000_6000, 8'd1);
        run_idle(100, to);
        checks++;
        if (to || beats[0] - b0 != 2 || last_data[0] !== fn(32'h8000_6000, 1) || errs() != 0) begin
            errors++;
            $display("FAIL reset_recover: timeout %0d beats %0d data %h errs %0d want 0 2 %h 0",
                     to, beats[0] - b0, last_data[0], errs(), fn(32'h8000_6000, 1));
        end
    endtask

    task automatic test_random();
        int issued [2] = '{0, 0};
        int exp_b [2] = '{0, 0};
        int d0 [2], b0 [2];
        int n;
        logic [7:0] l;
        bit busy;
        s_ar_mode = 2; s_r_mode = 0; m_rmode = '{0, 0};
        d0 = done; b0 = beats;
        n = 0;
        busy = 1;
        while (busy && n < 20000) begin
            for (int m = 0; m < 2; m++) begin
                if (!m_req[m] && !out_active[m] && issued[m] < 12 && $urandom_range(0, 2) == 0) begin
                    l = 8'($urandom_range(0, 7));
                    issue(m, $urandom & 32'hffff_fff8, l);
                    issued[m]++;
                    exp_b[m] += int'(l) + 1;
                end
            end
            tick();
            n++;
            busy = (issued[0] < 12 || issued[1] < 12 || m_req != 0 || out_active != 0 || s_q.size() != 0);
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL random_timeout: still busy after %0d cycles", n);
        end
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (done[m] - d0[m] != 12 || beats[m] - b0[m] != exp_b[m]) begin
                errors++;
                $display("FAIL random_m%0d: bursts %0d beats %0d want 12 %0d", m, done[m] - d0[m], beats[m] - b0[m], exp_b[m]);
            end
        end
        checks++;
        if (errs() != 0) begin
            errors++;
            $display("FAIL random_clean: data %0d last %0d route %0d stray %0d ar %0d overlap %0d gap %0d want all 0",
                     data_err, last_err, route_err, stray_err, ar_err, overlap_err, gap_err);
        end
    endtask

    initial begin
        test_reset();
        test_stray();
        test_single();
        test_priority();
        test_mid_burst();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
